instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: issues in-order instruction memory requests
// under a credit limit, tracks outstanding responses, discards responses that
// belong to a redirected (flushed) stream, and buffers returned instructions
// for the decode stage.
module instr_fetch_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  i_rst_IF,
    input  logic [DATA_WIDTH-1:0] i_pc_IF,
    input  logic [DATA_WIDTH-1:0] i_pcplus4_IF,
    input  logic                  i_flush_IF,
    output logic                  o_en_IF,
    output logic                  o_imem_req,
    output logic [DATA_WIDTH-1:0] o_imem_addr,
    input  logic                  i_imem_gnt,
    input  logic                  i_imem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata,
    output logic                  o_instr_valid_ID,
    output logic [DATA_WIDTH-1:0] o_instr_ID,
    output logic [DATA_WIDTH-1:0] o_pc_ID,
    output logic [DATA_WIDTH-1:0] o_pcplus4_ID,
    input  logic                  i_ready_ID
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

    // Outstanding responses, responses still to be discarded, buffered count.
    logic [CW-1:0] os_cnt, os_next, disc_cnt, buf_cnt;
    logic [CW:0]   credit_used;

    logic [PW-1:0] pend_wr, pend_rd, buf_wr, buf_rd;

    logic [DATA_WIDTH-1:0] pend_pc   [DEPTH];
    logic [DATA_WIDTH-1:0] pend_pcp4 [DEPTH];
    logic [DATA_WIDTH-1:0] buf_instr [DEPTH];
    logic [DATA_WIDTH-1:0] buf_pc    [DEPTH];
    logic [DATA_WIDTH-1:0] buf_pcp4  [DEPTH];

    logic accept, keep, pop;

    assign credit_used      = {1'b0, os_cnt} + {1'b0, buf_cnt};
    assign o_imem_req       = !i_rst_IF && !i_flush_IF && (credit_used < CREDIT_MAX);
    assign o_imem_addr      = i_pc_IF;
    assign accept           = o_imem_req && i_imem_gnt;
    assign o_en_IF          = accept || i_flush_IF;
    assign keep             = i_imem_rvalid && (disc_cnt == '0) && !i_flush_IF;
    assign o_instr_valid_ID = (buf_cnt != '0) && !i_flush_IF;
    assign pop              = o_instr_valid_ID && i_ready_ID;
    assign o_instr_ID       = buf_instr[buf_rd];
    assign o_pc_ID          = buf_pc[buf_rd];
    assign o_pcplus4_ID     = buf_pcp4[buf_rd];

    // Next outstanding count: +1 on acceptance, -1 on each response.
    always_comb begin
        os_next = os_cnt;
        if (accept && !i_imem_rvalid) begin
            os_next = os_cnt + CW'(1);
        end else if (!accept && i_imem_rvalid) begin
            os_next = os_cnt - CW'(1);
        end
    end

    // Outstanding and discard counters; a flush marks every remaining response stale.
    always_ff @(posedge clk or posedge i_rst_IF) begin
        if (i_rst_IF) begin
            os_cnt   <= '0;
            disc_cnt <= '0;
        end else begin
            os_cnt <= os_next;
            if (i_flush_IF) begin
                disc_cnt <= os_next;
            end else if (i_imem_rvalid && disc_cnt != '0) begin
                disc_cnt <= disc_cnt - CW'(1);
            end
        end
    end

    // Pending FIFO pointers: push on acceptance, pop on every response.
    always_ff @(posedge clk or posedge i_rst_IF) begin
        if (i_rst_IF) begin
            pend_wr <= '0;
            pend_rd <= '0;
        end else begin
            if (accept) begin
                pend_wr <= pend_wr + PW'(1);
            end
            if (i_imem_rvalid) begin
                pend_rd <= pend_rd + PW'(1);
            end
        end
    end

    // Pending FIFO storage: PC pair of each accepted fetch.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_pc[pend_wr]   <= i_pc_IF;
            pend_pcp4[pend_wr] <= i_pcplus4_IF;
        end
    end

    // Output FIFO: fill from kept responses, drain on decode handshake, empty on flush.
    always_ff @(posedge clk or posedge i_rst_IF) begin
        if (i_rst_IF) begin
            buf_wr  <= '0;
            buf_rd  <= '0;
            buf_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
                buf_pcp4[i]  <= '0;
            end
        end else if (i_flush_IF) begin
            buf_wr  <= '0;
            buf_rd  <= '0;
            buf_cnt <= '0;
        end else begin
            if (keep) begin
                buf_instr[buf_wr] <= i_imem_rdata;
                buf_pc[buf_wr]    <= pend_pc[pend_rd];
                buf_pcp4[buf_wr]  <= pend_pcp4[pend_rd];
                buf_wr            <= buf_wr + PW'(1);
            end
            if (pop) begin
                buf_rd <= buf_rd + PW'(1);
            end
            if (keep && !pop) begin
                buf_cnt <= buf_cnt + CW'(1);
            end else if (pop && !keep) begin
                buf_cnt <= buf_cnt - CW'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (i_rst_IF)
        !(keep && !pop && buf_cnt == FULL_CNT));
    a_rvalid_has_request: assert property (@(posedge clk) disable iff (i_rst_IF)
        !(i_imem_rvalid && os_cnt == '0));
    a_discard_bounded: assert property (@(posedge clk) disable iff (i_rst_IF)
        disc_cnt <= os_cnt);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: a PC generator and in-order memory model drive
// the DUT; a queue-based model of in-flight fetches predicts request credit,
// valid and the instruction stream seen by decode.
`timescale 1ns/1ps
module tb_instr_fetch_ctrl;

    localparam int unsigned DW    = 32;
    // A DEPTH of 4 lets the credit loop sustain one instruction per cycle.
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          i_rst_IF;
    logic [DW-1:0] i_pc_IF, i_pcplus4_IF;
    logic          i_flush_IF;
    logic          o_en_IF, o_imem_req;
    logic [DW-1:0] o_imem_addr;
    logic          i_imem_gnt, i_imem_rvalid;
    logic [DW-1:0] i_imem_rdata;
    logic          o_instr_valid_ID;
    logic [DW-1:0] o_instr_ID, o_pc_ID, o_pcplus4_ID;
    logic          i_ready_ID;

    instr_fetch_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .i_rst_IF         (i_rst_IF),
        .i_pc_IF          (i_pc_IF),
        .i_pcplus4_IF     (i_pcplus4_IF),
        .i_flush_IF       (i_flush_IF),
        .o_en_IF          (o_en_IF),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_imem_gnt       (i_imem_gnt),
        .i_imem_rvalid    (i_imem_rvalid),
        .i_imem_rdata     (i_imem_rdata),
        .o_instr_valid_ID (o_instr_valid_ID),
        .o_instr_ID       (o_instr_ID),
        .o_pc_ID          (o_pc_ID),
        .o_pcplus4_ID     (o_pcplus4_ID),
        .i_ready_ID       (i_ready_ID)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [DW-1:0] pc; logic live; } fetch_t;
    typedef struct packed { logic [DW-1:0] instr; logic [DW-1:0] pc; logic [DW-1:0] pcp4; } deliv_t;

    fetch_t pend_q[$];   // granted, response not yet returned
    deliv_t exp_q[$];    // expected instructions for decode, in order

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] pc_m = '0;
    logic [DW-1:0] tgt = '0;
    logic [DW-1:0] tgt_fixed = '0;
    logic          fix_tgt = 1'b0;
    int unsigned   gnt_pct, rv_pct, rdy_pct, fl_pct;

    logic s_ok = 1'b0, s_acc = 1'b0, s_flush = 1'b0, s_rv = 1'b0, s_en = 1'b0;
    int   cyc = 0, first_gnt = -1, first_val = -1, nval = 0, ngnt = 0;
    logic found;

    function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs with the model every cycle, pop on handshake.
    always @(negedge clk) begin
        logic exp_req, exp_valid;
        if (i_rst_IF) begin
            s_ok = 1'b0;
        end else begin
            exp_req   = !i_flush_IF && ((pend_q.size() + exp_q.size()) < DEPTH);
            exp_valid = !i_flush_IF && (exp_q.size() > 0);
            chk1("imem_req", o_imem_req, exp_req);
            if (o_imem_req) chk("imem_addr", o_imem_addr, pc_m);
            chk1("en_IF", o_en_IF, (exp_req && i_imem_gnt) || i_flush_IF);
            chk1("instr_valid", o_instr_valid_ID, exp_valid);
            if (o_instr_valid_ID && exp_q.size() > 0) begin
                chk("instr", o_instr_ID, exp_q[0].instr);
                chk("pc_ID", o_pc_ID, exp_q[0].pc);
                chk("pcplus4_ID", o_pcplus4_ID, exp_q[0].pcp4);
                if (i_ready_ID) exp_q.delete(0);
            end
            if (o_imem_req && i_imem_gnt) begin
                ngnt++;
                if (first_gnt < 0) first_gnt = cyc;
            end
            if (o_instr_valid_ID) begin
                nval++;
                if (first_val < 0) first_val = cyc;
            end
            cyc++;
            s_ok    = 1'b1;
            s_acc   = o_imem_req && i_imem_gnt;
            s_flush = i_flush_IF;
            s_rv    = i_imem_rvalid;
            s_en    = o_en_IF;
        end
    end

    task automatic apply_cycle();
        fetch_t f;
        deliv_t d;
        if (s_ok) begin
            if (s_flush) begin
                foreach (pend_q[i]) pend_q[i].live = 1'b0;
                exp_q.delete();
            end
            if (s_rv && pend_q.size() > 0) begin
                f = pend_q.pop_front();
                if (f.live) begin
                    d.instr = mem_word(f.pc);
                    d.pc    = f.pc;
                    d.pcp4  = f.pc + 32'd4;
                    exp_q.push_back(d);
                end
            end
            if (s_acc) begin
                f.pc   = pc_m;
                f.live = 1'b1;
                pend_q.push_back(f);
            end
            if (s_en) pc_m = s_flush ? tgt : pc_m + 32'd4;
        end
        s_ok = 1'b0;
    endtask

    task automatic drive_inputs();
        i_pc_IF      = pc_m;
        i_pcplus4_IF = pc_m + 32'd4;
        i_flush_IF   = ($urandom_range(0, 99) < fl_pct);
        if (i_flush_IF) tgt = fix_tgt ? tgt_fixed : ($urandom_range(0, 4095) & 32'hFFFF_FFFC);
        i_imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
        i_imem_rvalid = (pend_q.size() > 0) && ($urandom_range(0, 99) < rv_pct);
        i_imem_rdata  = $urandom;
        if (i_imem_rvalid) i_imem_rdata = mem_word(pend_q[0].pc);
        i_ready_ID    = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        apply_cycle();
        drive_inputs();
    endtask

    task automatic set_knobs(input int unsigned g, input int unsigned r, input int unsigned y, input int unsigned f);
        gnt_pct = g;
        rv_pct  = r;
        rdy_pct = y;
        fl_pct  = f;
    endtask

    task automatic clear_model();
        pend_q.delete();
        exp_q.delete();
        pc_m          = '0;
        s_ok          = 1'b0;
        i_flush_IF    = 1'b0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = '0;
        i_ready_ID    = 1'b0;
        i_pc_IF       = '0;
        i_pcplus4_IF  = 32'd4;
    endtask

    task automatic mark();
        cyc = 0; first_gnt = -1; first_val = -1; nval = 0; ngnt = 0;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        i_rst_IF = 1'b1;
        clear_model();
        @(posedge clk);
        #2;
        chk1("rst_req", o_imem_req, 1'b0);
        chk1("rst_valid", o_instr_valid_ID, 1'b0);
        chk("rst_instr", o_instr_ID, '0);
        chk("rst_pc", o_pc_ID, '0);
        chk("rst_pcplus4", o_pcplus4_ID, '0);
        chk1("rst_en_noflush", o_en_IF, 1'b0);
        i_flush_IF = 1'b1;
        #1;
        chk1("rst_en_flush", o_en_IF, 1'b1);
        chk1("rst_req_flush", o_imem_req, 1'b0);
        i_flush_IF = 1'b0;
        @(posedge clk);
        #1;
        i_rst_IF = 1'b0;
        mark();
        drive_inputs();
    endtask

    task automatic async_reset_pulse();
        #2;
        i_rst_IF = 1'b1;
        #1;
        chk1("async_rst_valid", o_instr_valid_ID, 1'b0);
        chk1("async_rst_req", o_imem_req, 1'b0);
        chk("async_rst_instr", o_instr_ID, '0);
        chk("async_rst_pc", o_pc_ID, '0);
        chk("async_rst_pcplus4", o_pcplus4_ID, '0);
        clear_model();
        @(posedge clk);
        #1;
        i_rst_IF = 1'b0;
        mark();
        drive_inputs();
    endtask

    task automatic wait_valid(input int limit, output logic hit);
        hit = 1'b0;
        for (int k = 0; k < limit && !hit; k++) begin
            step();
            #1;
            if (o_instr_valid_ID) hit = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_IF = 1'b1;
        clear_model();
        set_knobs(0, 0, 0, 0);

        // Full-rate streaming from reset.
        set_knobs(100, 100, 100, 0);
        reset_dut();
        repeat (12) step();
        chk("first_grant_cycle", first_gnt, 0);
        chk("first_valid_cycle", first_val, 2);
        chk("valid_cycles", nval, 10);

        // Decode stalled: credit limits grants to DEPTH, then resumes.
        set_knobs(100, 100, 0, 0);
        reset_dut();
        repeat (10) step();
        #1;
        chk("grants_while_stalled", ngnt, DEPTH);
        chk1("req_stalled", o_imem_req, 1'b0);
        chk1("en_stalled", o_en_IF, 1'b0);
        rdy_pct = 100;
        repeat (20) step();

        // Grant withheld: request and address held, PC not advanced.
        set_knobs(0, 100, 100, 0);
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1("req_held", o_imem_req, 1'b1);
            chk("addr_held", o_imem_addr, '0);
            chk1("en_held", o_en_IF, 1'b0);
            step();
        end
        gnt_pct = 100;
        step();
        #1;
        chk1("en_on_grant", o_en_IF, 1'b1);
        repeat (10) step();

        // Flush with nothing outstanding, then flush with two fetches in flight.
        set_knobs(100, 0, 100, 100);
        fix_tgt   = 1'b1;
        tgt_fixed = 32'h10;
        reset_dut();
        fl_pct = 0;
        step();
        #1;
        chk1("req_after_idle_flush", o_imem_req, 1'b1);
        chk("addr_after_idle_flush", o_imem_addr, 32'h10);
        step();
        fl_pct    = 100;
        tgt_fixed = 32'h40;
        step();
        #1;
        chk1("req_on_flush", o_imem_req, 1'b0);
        chk1("en_on_flush", o_en_IF, 1'b1);
        fl_pct = 0;
        rv_pct = 100;
        wait_valid(20, found);
        chk1("valid_after_redirect", found, 1'b1);
        chk("first_pc_after_redirect", o_pc_ID, 32'h40);
        repeat (5) step();

        // Flush coinciding with rvalid and ready while one instruction is buffered.
        set_knobs(100, 0, 0, 0);
        tgt_fixed = 32'h80;
        reset_dut();
        step();
        gnt_pct = 0;
        step();
        rv_pct = 100;
        step();
        rv_pct = 0;
        step();
        #1;
        chk1("one_buffered", o_instr_valid_ID, 1'b1);
        set_knobs(0, 100, 100, 100);
        step();
        #1;
        chk1("valid_on_flush", o_instr_valid_ID, 1'b0);
        set_knobs(100, 100, 100, 0);
        wait_valid(20, found);
        chk1("valid_after_flush_rvalid", found, 1'b1);
        chk("first_pc_after_flush_rvalid", o_pc_ID, 32'h80);
        fix_tgt = 1'b0;

        // Asynchronous reset with one outstanding and one buffered.
        set_knobs(70, 50, 30, 0);
        reset_dut();
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            if (pend_q.size() == 1 && exp_q.size() == 1) found = 1'b1;
        end
        async_reset_pulse();
        #1;
        chk1("restart_req", o_imem_req, 1'b1);
        chk("restart_addr", o_imem_addr, '0);
        repeat (30) step();

        // Randomized traffic with flushes and occasional mid-stream resets.
        for (int seg = 0; seg < 30; seg++) begin
            set_knobs($urandom_range(20, 100), $urandom_range(20, 100),
                      $urandom_range(10, 100), $urandom_range(0, 8));
            repeat (80) step();
            if (seg % 6 == 5) async_reset_pulse();
        end

        // Drain: no new grants, everything buffered must reach decode.
        set_knobs(0, 100, 100, 0);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            step();
            if (pend_q.size() == 0 && exp_q.size() == 0) found = 1'b1;
        end
        chk1("drain", found, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
